chan_acq_responder: RTL and testbench
=====================================

Name: chan_acq_responder

Overview:
- Channel-side endpoint of the acquisition handshake driven by the channel acquisition controller (enable / trigger / done), running on the 40 MHz TTC clock domain.
- On a trigger while armed, it latches the trigger type and the per-channel burst and waveform counts. It then issues one DDR3 burst-write command per burst of every waveform and reports completion on acq_done.
- One instance per channel FPGA. It also serves as the channel model in system benches.

Parameters:
- ADDR_WIDTH, 26, width of the DDR3 burst address.
- BURST_STRIDE, 8, address increment per burst command.
- TIMEOUT_CYCLES, 4096, stall limit for the optional watchdog.

Ports:
- clk  in  1  40 MHz TTC clock
- reset  in  1  synchronous, active-high
- acq_enable  in  2  trigger type / arm: 00 disabled, 01 muon, 10 laser, 11 pedestal
- acq_trig  in  1  single-cycle trigger pulse
- acq_done  out  1  high when idle or when acquisition is complete
- burst_count  in  23  bursts per waveform, static between triggers
- wfm_count  in  12  waveforms per fill, static between triggers
- cmd_valid  out  1  burst-write command valid
- cmd_ready  in  1  DDR3 controller accepts the command
- cmd_addr  out  ADDR_WIDTH  burst start address
- cmd_last  out  1  marks the final command of the event
- cmd_type  out  2  latched trigger type
- event_count  out  24  completed acquisitions, starts at 0
- error_trig_overlap  out  1  sticky: a trigger arrived while not ARMED but enabled
- error_timeout  out  1  sticky watchdog error (tied 0 without the macro)

Behaviour:
- Reset values: acq_done=1, cmd_valid=0, cmd_addr=0, cmd_last=0, cmd_type=0, event_count=0, both error flags 0, state IDLE, next-event base address 0.
- State IDLE: acq_done=1. Moves to ARMED when acq_enable!=00.
- State ARMED: acq_done=0. If acq_enable returns to 00 before a trigger, goes back to IDLE. On acq_trig, latches type, burst_count, wfm_count (pedestal forces wfm=1), then goes to ACQUIRE. cmd_valid rises on the next cycle (latency 1).
- State ACQUIRE: on each cmd_valid&&cmd_ready handshake, cmd_addr advances by BURST_STRIDE.
  - The inner burst counter wraps at burst_count and increments the waveform counter.
  - cmd_last=1 on the final command of the event.
  - cmd_valid/cmd_addr hold stable while cmd_ready=0 (AXI-style, no retraction).
- After the last handshake: state DONE. acq_done=1 on the cycle after the handshake; event_count increments once; the base address register is set to the address following the last command.
- State DONE: holds acq_done=1 until acq_enable=00, then goes to IDLE.
- Zero count: burst_count==0 or wfm_count==0 at trigger goes directly to DONE with no commands; event_count still increments.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- acq_trig in ACQUIRE or DONE is ignored and sets error_trig_overlap. acq_trig in IDLE with acq_enable=00 is ignored silently.
- acq_enable dropping mid-ACQUIRE does not abort. Latched values complete; the block then goes straight to IDLE.
- Total commands per event = burst_count*wfm_count. The product is 35 bits; only the counters are needed, no multiplier.
- Reset mid-ACQUIRE: cmd_valid drops in the same cycle reset is sampled; the partial event is not counted.

Optional Feature:
- CHAN_ACQ_TIMEOUT_EN defined: a watchdog counts consecutive cycles with cmd_valid&&!cmd_ready.
  - On reaching TIMEOUT_CYCLES: sets error_timeout, drops cmd_valid, goes to DONE without incrementing event_count.
  - The next event's base address is the address of the stalled command.
- Undefined: no watchdog; error_timeout is tied to 0 and ACQUIRE waits indefinitely.

Decomposition:
- Shared package holds: trigger-type constants (TRIG_NONE=0, TRIG_MUON=1, TRIG_LASER=2, TRIG_PEDESTAL=3) and the state encoding constants.
- One natural sub-module: acq_burst_sequencer, the burst/waveform nested counter with address generator and cmd_last logic.
- The FSM and the watchdog stay in the top.

Test Plan:
- enable=01, burst_count=4, wfm_count=3, trig, cmd_ready=1 -> 12 commands at addresses 0..88 step 8; cmd_last only on the 12th; acq_done 1 cycle later; event_count=1.
- Second event of the same size after enable toggles 00 -> 01 -> addresses start at 96; event_count=2.
- enable=11, wfm_count=5, burst_count=2 -> exactly 2 commands (pedestal forces one waveform); cmd_type=11.
- cmd_ready held 0 for 10 cycles mid-event -> cmd_valid/cmd_addr stable, no lost or duplicated addresses.
- Second acq_trig during ACQUIRE -> ignored, error_trig_overlap=1; the command total is unchanged.
- burst_count=0, trig -> no cmd_valid; acq_done back to 1 within 2 cycles; event_count increments.
- With CHAN_ACQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, cmd_ready=0 -> error_timeout=1 after 16 stalled cycles; DONE reached; event_count unchanged.

Source files
------------

// File: rtl/chan_acq_responder_pkg.sv
// Shared types and constants for the channel acquisition responder.
// No logic; trigger-type codes, counter widths and FSM state encoding.
// Imported by the top and by the burst sequencer.
package chan_acq_responder_pkg;

  localparam logic [1:0] TRIG_NONE     = 2'd0;
  localparam logic [1:0] TRIG_MUON     = 2'd1;
  localparam logic [1:0] TRIG_LASER    = 2'd2;
  localparam logic [1:0] TRIG_PEDESTAL = 2'd3;

  localparam int BURST_CNT_W = 23;
  localparam int WFM_CNT_W   = 12;
  localparam int EVENT_CNT_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Pedestal events always capture exactly one waveform.
  function automatic logic [WFM_CNT_W-1:0] eff_wfm_count(input logic [1:0]           trig_type,
                                                          input logic [WFM_CNT_W-1:0] wfm_count);
    return (trig_type == TRIG_PEDESTAL) ? WFM_CNT_W'(1) : wfm_count;
  endfunction

endpackage

// File: rtl/chan_acq_responder_burst_seq.sv
// Burst/waveform nested counter emitting one burst-write command per burst.
// Latency: cmd_valid_o rises the cycle after load_i; one command per cycle when ready.
// Backpressure: valid/addr/last hold while cmd_ready_i is low; abort_i drops valid.
module acq_burst_sequencer
  import chan_acq_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = 26,
  parameter int BURST_STRIDE = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic                   abort_i,
  input  logic [BURST_CNT_W-1:0] burst_lim_i,
  input  logic [WFM_CNT_W-1:0]   wfm_lim_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic                   cmd_ready_i,
  output logic                   cmd_valid_o,
  output logic [ADDR_WIDTH-1:0]  cmd_addr_o,
  output logic                   cmd_last_o,
  output logic                   last_hs_o,
  output logic [ADDR_WIDTH-1:0]  next_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BURST_STRIDE);

  logic                   valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BURST_CNT_W-1:0] burst_idx_q, burst_idx_d, burst_lim_q, burst_lim_d;
  logic [WFM_CNT_W-1:0]   wfm_idx_q, wfm_idx_d, wfm_lim_q, wfm_lim_d;
  logic                   burst_wrap, is_last, hs;

  // Indices never exceed limit-1, so idx+1 cannot overflow the counter width.
  assign burst_wrap  = (burst_idx_q + BURST_CNT_W'(1)) == burst_lim_q;
  assign is_last     = burst_wrap && ((wfm_idx_q + WFM_CNT_W'(1)) == wfm_lim_q);
  assign hs          = valid_q && cmd_ready_i;
  // Valid is masked by reset so an in-flight command vanishes as reset is sampled.
  assign cmd_valid_o = valid_q && !reset_i;
  assign cmd_addr_o  = addr_q;
  assign cmd_last_o  = valid_q && is_last && !reset_i;
  assign last_hs_o   = hs && is_last;
  assign next_addr_o = addr_q + STRIDE;

  // Sequencer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q     <= 1'b0;
      addr_q      <= '0;
      burst_idx_q <= '0;
      burst_lim_q <= '0;
      wfm_idx_q   <= '0;
      wfm_lim_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      burst_idx_q <= burst_idx_d;
      burst_lim_q <= burst_lim_d;
      wfm_idx_q   <= wfm_idx_d;
      wfm_lim_q   <= wfm_lim_d;
    end
  end

  // Load a new event, abort, or step the nested counters on each handshake.
  always_comb begin
    valid_d     = valid_q;
    addr_d      = addr_q;
    burst_idx_d = burst_idx_q;
    burst_lim_d = burst_lim_q;
    wfm_idx_d   = wfm_idx_q;
    wfm_lim_d   = wfm_lim_q;
    if (load_i) begin
      valid_d     = 1'b1;
      addr_d      = base_addr_i;
      burst_idx_d = '0;
      wfm_idx_d   = '0;
      burst_lim_d = burst_lim_i;
      wfm_lim_d   = wfm_lim_i;
    end else if (abort_i) begin
      valid_d = 1'b0;
    end else if (hs) begin
      addr_d = addr_q + STRIDE;
      if (burst_wrap) begin
        burst_idx_d = '0;
        wfm_idx_d   = wfm_idx_q + WFM_CNT_W'(1);
      end else begin
        burst_idx_d = burst_idx_q + BURST_CNT_W'(1);
      end
      if (is_last) valid_d = 1'b0;
    end
  end

endmodule

// File: rtl/chan_acq_responder.sv
// Channel-side acquisition endpoint: arm/trigger FSM issuing DDR3 burst-write commands.
// Latency: first command the cycle after the trigger; acq_done the cycle after the last handshake.
// Backpressure: commands stall on cmd_ready; optional CHAN_ACQ_TIMEOUT_EN watchdog aborts a stuck event.
module chan_acq_responder
  import chan_acq_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = 26,
  parameter int BURST_STRIDE   = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             acq_enable,
  input  logic                   acq_trig,
  output logic                   acq_done,
  input  logic [BURST_CNT_W-1:0] burst_count,
  input  logic [WFM_CNT_W-1:0]   wfm_count,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ADDR_WIDTH-1:0]  cmd_addr,
  output logic                   cmd_last,
  output logic [1:0]             cmd_type,
  output logic [EVENT_CNT_W-1:0] event_count,
  output logic                   error_trig_overlap,
  output logic                   error_timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [1:0]             type_q, type_d;
  logic [EVENT_CNT_W-1:0] evt_q, evt_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic                   ovl_q, ovl_d;
  logic                   seq_load, seq_abort, seq_last_hs;
  logic [ADDR_WIDTH-1:0]  seq_next_addr;
  logic [WFM_CNT_W-1:0]   wfm_eff;
  logic                   zero_count, trig_overlap, timeout_hit;

  assign wfm_eff      = eff_wfm_count(acq_enable, wfm_count);
  assign zero_count   = (burst_count == '0) || (wfm_eff == '0);
  assign trig_overlap = acq_trig && ((state_q == ST_ACQUIRE) || (state_q == ST_DONE) ||
                                     ((state_q == ST_IDLE) && (acq_enable != TRIG_NONE)));

  assign acq_done           = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign cmd_type           = type_q;
  assign event_count        = evt_q;
  assign error_trig_overlap = ovl_q;

  acq_burst_sequencer #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .BURST_STRIDE (BURST_STRIDE)
  ) u_seq (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (seq_load),
    .abort_i     (seq_abort),
    .burst_lim_i (burst_count),
    .wfm_lim_i   (wfm_eff),
    .base_addr_i (base_q),
    .cmd_ready_i (cmd_ready),
    .cmd_valid_o (cmd_valid),
    .cmd_addr_o  (cmd_addr),
    .cmd_last_o  (cmd_last),
    .last_hs_o   (seq_last_hs),
    .next_addr_o (seq_next_addr)
  );

`ifdef CHAN_ACQ_TIMEOUT_EN
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            tout_q, tout_d;
  logic            stall;

  assign stall         = (state_q == ST_ACQUIRE) && cmd_valid && !cmd_ready;
  assign timeout_hit   = stall && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign error_timeout = tout_q;

  // Count consecutive stalled cycles; any accepted or idle cycle restarts the count.
  always_comb begin
    wdog_d = '0;
    tout_d = tout_q | timeout_hit;
    if (stall && !timeout_hit) wdog_d = wdog_q + WD_W'(1);
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
      tout_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tout_q <= tout_d;
    end
  end
`else
  logic [WD_W-1:0] unused_wd_limit;

  assign unused_wd_limit = WD_W'(TIMEOUT_CYCLES);
  assign timeout_hit     = 1'b0;
  assign error_timeout   = 1'b0;
`endif

  // FSM and event bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      type_q  <= TRIG_NONE;
      evt_q   <= '0;
      base_q  <= '0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      evt_q   <= evt_d;
      base_q  <= base_d;
      ovl_q   <= ovl_d;
    end
  end

  // Next-state: arm on enable, latch on trigger, finish on last handshake or watchdog.
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    evt_d     = evt_q;
    base_d    = base_q;
    ovl_d     = ovl_q | trig_overlap;
    seq_load  = 1'b0;
    seq_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acq_enable != TRIG_NONE) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (acq_enable == TRIG_NONE) begin
          state_d = ST_IDLE;
        end else if (acq_trig) begin
          type_d = acq_enable;
          if (zero_count) begin
            state_d = ST_DONE;
            evt_d   = evt_q + EVENT_CNT_W'(1);
          end else begin
            state_d  = ST_ACQUIRE;
            seq_load = 1'b1;
          end
        end
      end
      ST_ACQUIRE: begin
        if (timeout_hit) begin
          // Resume the next event at the command that never got accepted.
          seq_abort = 1'b1;
          base_d    = cmd_addr;
          state_d   = ST_DONE;
        end else if (seq_last_hs) begin
          evt_d   = evt_q + EVENT_CNT_W'(1);
          base_d  = seq_next_addr;
          // A disarm seen during the event skips the DONE hold entirely.
          state_d = (acq_enable == TRIG_NONE) ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        if (acq_enable == TRIG_NONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_chan_acq_responder.sv
// Self-checking bench for chan_acq_responder.
// Table of events applied in a loop; expected commands scoreboarded and checked per handshake.
// Extra hand-written sequences cover reset mid-event and the optional watchdog.
module tb_chan_acq_responder;
  localparam int AW = 26;

  logic          clk;
  logic          reset;
  logic [1:0]    acq_enable;
  logic          acq_trig;
  logic          acq_done;
  logic [22:0]   burst_count;
  logic [11:0]   wfm_count;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_last;
  logic [1:0]    cmd_type;
  logic [23:0]   event_count;
  logic          error_trig_overlap;
  logic          error_timeout;

  chan_acq_responder #(
    .ADDR_WIDTH     (AW),
    .BURST_STRIDE   (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .acq_enable         (acq_enable),
    .acq_trig           (acq_trig),
    .acq_done           (acq_done),
    .burst_count        (burst_count),
    .wfm_count          (wfm_count),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_addr           (cmd_addr),
    .cmd_last           (cmd_last),
    .cmd_type           (cmd_type),
    .event_count        (event_count),
    .error_trig_overlap (error_trig_overlap),
    .error_timeout      (error_timeout)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          last;
    logic [1:0]    typ;
  } exp_t;

  typedef struct {
    logic [1:0]  en;
    logic [22:0] bc;
    logic [11:0] wc;
    int          ncmd;
    bit          stall;
    bit          dbl;
  } vec_t;

  exp_t          sb_q[$];
  vec_t          vecs[7];
  int            checks;
  int            errors;
  logic [AW-1:0] exp_base;
  logic [23:0]   exp_events;
  bit            mon_prev_stall;
  logic [AW-1:0] mon_prev_addr;
  bit            mon_done_pend;
  exp_t          mon_item;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted command must match the head of the queue.
  initial begin
    mon_prev_stall = 1'b0;
    mon_prev_addr  = '0;
    mon_done_pend  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_prev_stall = 1'b0;
        mon_done_pend  = 1'b0;
      end else begin
        if (mon_done_pend) begin
          chk("done_after_last", acq_done, 1);
          mon_done_pend = 1'b0;
        end
        if (mon_prev_stall && !error_timeout) begin
          chk("hold_valid", cmd_valid, 1);
          chk("hold_addr", cmd_addr, mon_prev_addr);
        end
        if (cmd_valid && cmd_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_cmd_queue", 64'(sb_q.size()), 64'd1);
          end else begin
            mon_item = sb_q.pop_front();
            chk("cmd_addr", cmd_addr, mon_item.addr);
            chk("cmd_last", cmd_last, mon_item.last);
            chk("cmd_type_live", cmd_type, mon_item.typ);
            if (mon_item.last) mon_done_pend = 1'b1;
          end
        end
        mon_prev_stall = cmd_valid && !cmd_ready;
        mon_prev_addr  = cmd_addr;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   c;
    exp_t item;
    burst_count = v.bc;
    wfm_count   = v.wc;
    acq_enable  = v.en;
    cmd_ready   = 1'b1;
    tick;
    tick;
    chk("armed_done_low", acq_done, 0);
    for (int k = 0; k < v.ncmd; k++) begin
      item.addr = exp_base + AW'(8 * k);
      item.last = (k == v.ncmd - 1);
      item.typ  = v.en;
      sb_q.push_back(item);
    end
    acq_trig = 1'b1;
    tick;
    acq_trig = 1'b0;
    if (v.ncmd > 0) chk("valid_latency", cmd_valid, 1);
    else            chk("zero_no_valid", cmd_valid, 0);
    if (v.dbl) begin
      tick;
      tick;
      chk("ovl_before", error_trig_overlap, 0);
      acq_trig = 1'b1;
      tick;
      acq_trig = 1'b0;
      chk("ovl_after", error_trig_overlap, 1);
    end
    if (v.stall) begin
      tick;
      tick;
      cmd_ready = 1'b0;
      repeat (10) tick;
      cmd_ready = 1'b1;
    end
    c = 0;
    while (!acq_done && c < 200) begin
      tick;
      c++;
    end
    chk("done_reached", acq_done, 1);
    if (v.ncmd == 0) chk("zero_done_latency", 64'(c <= 1), 1);
    chk("all_cmds_seen", 64'(sb_q.size()), 0);
    exp_events = exp_events + 24'd1;
    exp_base   = exp_base + AW'(8 * v.ncmd);
    chk("event_count", event_count, exp_events);
    chk("cmd_type", cmd_type, v.en);
    chk("valid_after_event", cmd_valid, 0);
    acq_enable = 2'b00;
    tick;
    tick;
    chk("idle_done_high", acq_done, 1);
  endtask

  initial begin
    int   c;
    exp_t item;
    checks      = 0;
    errors      = 0;
    exp_base    = '0;
    exp_events  = '0;
    reset       = 1'b1;
    acq_enable  = 2'b00;
    acq_trig    = 1'b0;
    burst_count = '0;
    wfm_count   = '0;
    cmd_ready   = 1'b1;

    //            en     bc      wc      n   stall dbl
    vecs[0] = '{2'b01, 23'd4, 12'd3, 12, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 23'd4, 12'd3, 12, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 23'd2, 12'd5,  2, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 23'd3, 12'd4, 12, 1'b1, 1'b0};
    vecs[4] = '{2'b01, 23'd2, 12'd3,  6, 1'b0, 1'b1};
    vecs[5] = '{2'b01, 23'd0, 12'd3,  0, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 23'd5, 12'd0,  0, 1'b0, 1'b0};

    repeat (3) tick;
    reset = 1'b0;
    tick;
    chk("rst_acq_done", acq_done, 1);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_last", cmd_last, 0);
    chk("rst_cmd_type", cmd_type, 0);
    chk("rst_event_count", event_count, 0);
    chk("rst_err_ovl", error_trig_overlap, 0);
    chk("rst_err_tout", error_timeout, 0);

    // Trigger while disabled is silently ignored.
    acq_trig = 1'b1;
    tick;
    acq_trig = 1'b0;
    tick;
    chk("idle_trig_ignored_ovl", error_trig_overlap, 0);
    chk("idle_trig_no_valid", cmd_valid, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

`ifdef CHAN_ACQ_TIMEOUT_EN
    acq_enable  = 2'b01;
    burst_count = 23'd4;
    wfm_count   = 12'd1;
    cmd_ready   = 1'b0;
    tick;
    tick;
    acq_trig = 1'b1;
    tick;
    acq_trig = 1'b0;
    c = 0;
    while (!acq_done && c < 100) begin
      tick;
      c++;
    end
    chk("tout_done", acq_done, 1);
    chk("tout_latency", 64'(c), 64'd16);
    chk("tout_flag", error_timeout, 1);
    chk("tout_valid_dropped", cmd_valid, 0);
    chk("tout_events", event_count, exp_events);
    chk("tout_stalled_addr", cmd_addr, exp_base);
    acq_enable = 2'b00;
    cmd_ready  = 1'b1;
    tick;
    tick;
`else
    chk("no_tout", error_timeout, 0);
`endif

    // Reset in the middle of an event: command drops at once, event not counted.
    burst_count = 23'd8;
    wfm_count   = 12'd8;
    acq_enable  = 2'b01;
    cmd_ready   = 1'b1;
    tick;
    tick;
    for (int k = 0; k < 64; k++) begin
      item.addr = exp_base + AW'(8 * k);
      item.last = (k == 63);
      item.typ  = 2'b01;
      sb_q.push_back(item);
    end
    acq_trig = 1'b1;
    tick;
    acq_trig = 1'b0;
    repeat (3) tick;
    chk("pre_rst_valid", cmd_valid, 1);
    reset = 1'b1;
    #1;
    chk("rst_valid_drop", cmd_valid, 0);
    sb_q.delete();
    tick;
    reset      = 1'b0;
    acq_enable = 2'b00;
    tick;
    chk("mid_rst_event_count", event_count, 0);
    chk("mid_rst_cmd_addr", cmd_addr, 0);
    chk("mid_rst_acq_done", acq_done, 1);
    chk("mid_rst_err_ovl", error_trig_overlap, 0);
    exp_base   = '0;
    exp_events = '0;
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
